dm_cache_controller: RTL
========================

Name: dm_cache_controller

Overview:
- Read-only, direct-mapped cache sitting between the CPU-side requester and main_memory.
- Accepts 15-bit word-address read requests and looks up a 1024-line tag/valid/data store.
- On a hit, returns the word from the stored line.
- On a miss, holds a line-aligned read to main memory for a fixed latency, captures the 128-bit line, fills the entry and then responds.

Parameters:
- ADDR_W, 15, word-address width; must match main memory.
- INDEX_W, 10, line index bits (1024 lines).
- OFFSET_W, 2, word-in-line bits (4 x 32-bit words per line).
- MEM_LATENCY, 2, cycles the memory read is held before the line is captured; must be >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- req_valid  input  1  CPU read request strobe.
- req_addr  input  ADDR_W  word address; sampled when req_valid && req_ready.
- req_ready  output  1  controller can accept a request (IDLE only).
- resp_valid  output  1  one-cycle pulse; resp_data valid.
- resp_data  output  32  requested word.
- resp_hit  output  1  qualifies resp_valid: 1 = hit, 0 = served by refill.
- mem_read_enable  output  1  held high during FILL.
- mem_address  output  ADDR_W  {tag,index,2'b00} of the missing line; 0 when not in FILL.
- mem_line_in  input  128  memory line; word k at bits [32k+31:32k].

Behaviour:
- Address split: offset = addr[1:0], index = addr[11:2], tag = addr[14:12] (TAG_W = ADDR_W-INDEX_W-OFFSET_W = 3).
- Reset (rst=0, asynchronous):
  - All 1024 valid bits cleared; FSM to IDLE; fill counter 0.
  - Outputs: req_ready=1, resp_valid=0, resp_data=0, resp_hit=0, mem_read_enable=0, mem_address=0.
  - Tag/data arrays are not cleared.
- FSM states: IDLE, LOOKUP, FILL, RESPOND.
  - IDLE: req_ready=1. On req_valid, register the address and go to LOOKUP. Otherwise stay.
  - LOOKUP: compare valid[index] && tag_array[index]==tag.
    - Hit: latch the selected word into resp_data, resp_hit=1, go to RESPOND.
    - Miss: counter=0, go to FILL.
  - FILL: mem_read_enable=1, mem_address=line address, counter increments each cycle. On the cycle with counter==MEM_LATENCY-1:
    - write mem_line_in into data_array[index] and tag into tag_array[index];
    - set valid[index];
    - latch word[offset] of mem_line_in into resp_data, resp_hit=0;
    - go to RESPOND.
  - RESPOND: resp_valid=1 for exactly this cycle, then IDLE. resp_data/resp_hit hold until the next response.
- Latency, with accept in cycle 0:
  - Hit: resp_valid in cycle 2.
  - Miss: resp_valid in cycle MEM_LATENCY+2.
  - Next accept earliest the cycle after RESPOND.
- No backpressure on the response; the requester must consume it in the resp_valid cycle.
- req_valid outside IDLE is ignored (req_ready=0). The requester holds its request until accepted.
- A miss to an index holding a different valid tag overwrites that entry; no write-back is needed (read-only).
- Reset asserted mid-FILL aborts the refill. The entry is not validated. mem_read_enable drops immediately (asynchronous).
- Address 32767 is cacheable like any other address.

Optional Feature:
- Macro: DM_CACHE_STATS_EN.
- When defined, the module adds:
  - output hit_count[15:0] and miss_count[15:0];
  - counters incremented in LOOKUP on hit/miss respectively;
  - counters saturate at 16'hFFFF and are cleared by rst.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package dm_cache_pkg holds:
  - constants ADDR_W, INDEX_W, OFFSET_W, TAG_W, LINE_W=128, WORD_W=32;
  - the FSM state enum (IDLE/LOOKUP/FILL/RESPOND);
  - the address-field slicing functions.
- One sub-module, dm_cache_store:
  - holds the tag, valid and data arrays;
  - synchronous write, combinational read, asynchronous valid clear.
- The FSM, counter and output registers stay in dm_cache_controller.

Test Plan:
- Cold miss: reset, then main memory reset (addresses 1024..8192 = 1). Read addr 0x0400 → mem_address=0x0400 with mem_read_enable for MEM_LATENCY cycles; resp_valid in cycle 4 (MEM_LATENCY=2); resp_data=1; resp_hit=0.
- Hit: repeat read of 0x0402 → resp_valid in cycle 2, resp_data=1, resp_hit=1, mem_read_enable stays 0.
- Conflict eviction: backdoor-load memory word 0x1400=32'hA5A5_0001, then read 0x1400 (same index 256, tag 1) → miss, resp_data=32'hA5A5_0001. A following read of 0x0400 → miss again, resp_data=1.
- Offset select: backdoor-load words 0x2000..0x2003 = 10,11,12,13. Read 0x2003 → 13 (miss); then 0x2000 → 10, 0x2001 → 11, 0x2002 → 12, all hits.
- Reset mid-fill: drop rst during the second FILL cycle for 0x0800 → mem_read_enable=0 at once, req_ready=1. After release, read 0x0800 → miss (entry not valid).
- Stats (DM_CACHE_STATS_EN): 1 miss + 3 hits → hit_count=3, miss_count=1. Force hit_count to 16'hFFFF and issue a hit → stays 16'hFFFF.

Source files
------------

// File: rtl/dm_cache_pkg.sv
// Shared constants, FSM state type and address-field helpers for the direct-mapped read cache.
package dm_cache_pkg;

    localparam int ADDR_W    = 15;
    localparam int INDEX_W   = 10;
    localparam int OFFSET_W  = 2;
    localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINE_W    = 128;
    localparam int WORD_W    = 32;
    localparam int NUM_LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FILL,
        RESPOND
    } cache_state_t;

    function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:0];
    endfunction

    function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    // Line-aligned address of the line containing addr.
    function automatic logic [ADDR_W-1:0] line_address(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

    function automatic logic [WORD_W-1:0] select_word(input logic [LINE_W-1:0] line,
                                                      input logic [OFFSET_W-1:0] offset);
        return line[offset*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/dm_cache_store.sv
// Tag, valid and data arrays of the direct-mapped cache.
// Synchronous write, combinational read; only the valid bits are cleared by reset.
module dm_cache_store
    import dm_cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [LINE_W-1:0]  wr_line,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_line
);

    logic [NUM_LINES-1:0] valid_bits;
    logic [TAG_W-1:0]     tag_array  [NUM_LINES];
    logic [LINE_W-1:0]    data_array [NUM_LINES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_bits <= '0;
        end else if (wr_en) begin
            valid_bits[wr_index] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset so they can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_array[wr_index]  <= wr_tag;
            data_array[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid_bits[rd_index];
    assign rd_tag   = tag_array[rd_index];
    assign rd_line  = data_array[rd_index];

endmodule

// File: rtl/dm_cache_controller.sv
// Read-only direct-mapped cache controller: lookup, fixed-latency line refill and response.
// Optional hit/miss counters are enabled by defining DM_CACHE_STATS_EN.
module dm_cache_controller
    import dm_cache_pkg::*;
#(
    parameter int MEM_LATENCY = 2
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               req_ready,
    output logic               resp_valid,
    output logic [WORD_W-1:0]  resp_data,
    output logic               resp_hit,
    output logic               mem_read_enable,
    output logic [ADDR_W-1:0]  mem_address,
    input  logic [LINE_W-1:0]  mem_line_in
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
`endif
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(MEM_LATENCY - 1);

    cache_state_t      state;
    cache_state_t      state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  fill_count;

    logic              store_valid;
    logic [TAG_W-1:0]  store_tag;
    logic [LINE_W-1:0] store_line;
    logic              lookup_hit;
    logic              fill_done;

    dm_cache_store u_store (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (fill_done),
        .wr_index (get_index(addr_q)),
        .wr_tag   (get_tag(addr_q)),
        .wr_line  (mem_line_in),
        .rd_index (get_index(addr_q)),
        .rd_valid (store_valid),
        .rd_tag   (store_tag),
        .rd_line  (store_line)
    );

    assign lookup_hit = store_valid && (store_tag == get_tag(addr_q));
    assign fill_done  = (state == FILL) && (fill_count == FILL_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = LOOKUP;
            LOOKUP:  state_next = lookup_hit ? RESPOND : FILL;
            FILL:    if (fill_done) state_next = RESPOND;
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and memory-request outputs decode straight from state, so an
    // asynchronous reset drops mem_read_enable without waiting for a clock.
    assign req_ready       = (state == IDLE);
    assign resp_valid      = (state == RESPOND);
    assign mem_read_enable = (state == FILL);
    assign mem_address     = mem_read_enable ? line_address(addr_q) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            fill_count <= '0;
            resp_data  <= '0;
            resp_hit   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                addr_q <= req_addr;
            end
            if (state == LOOKUP) begin
                fill_count <= '0;
            end else if (state == FILL) begin
                fill_count <= fill_count + CNT_W'(1);
            end
            if (state == LOOKUP && lookup_hit) begin
                resp_data <= select_word(store_line, get_offset(addr_q));
                resp_hit  <= 1'b1;
            end else if (fill_done) begin
                resp_data <= select_word(mem_line_in, get_offset(addr_q));
                resp_hit  <= 1'b0;
            end
        end
    end

`ifdef DM_CACHE_STATS_EN
    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (lookup_hit) begin
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule
